// File: rtl/cpu_pkg.sv
// Shared load-path types: access size, load FSM states, and the reserved PC register index.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package cpu_pkg;

    typedef enum logic [1:0] {
        LS_BYTE = 2'b00,
        LS_HALF = 2'b01,
        LS_WORD = 2'b10,
        LS_RSVD = 2'b11
    } load_size_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_WB   = 2'b11
    } load_state_t;

    localparam logic [3:0] PC_REG = 4'd15;

    // A load is refused when misaligned for its size, of reserved size, or targeting the PC.
    function automatic logic load_reject(input logic [1:0] addr_lo, input load_size_t size,
                                         input logic [3:0] rd);
        logic bad;
        bad = (rd == PC_REG);
        case (size)
            LS_HALF: bad = bad | addr_lo[0];
            LS_WORD: bad = bad | (addr_lo != 2'b00);
            LS_RSVD: bad = 1'b1;
            default: bad = bad;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_align.sv
// Selects the byte/halfword/word lane of a little-endian memory word and sign/zero extends it.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module load_align
    import cpu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  load_size_t  size,
    input  logic        is_signed,
    output logic [31:0] result
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = rdata[{addr_lo, 3'b000} +: 8];
        half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        result    = 32'd0;
        case (size)
            LS_BYTE: result = {{24{is_signed & byte_lane[7]}}, byte_lane};
            LS_HALF: result = {{16{is_signed & half_lane[15]}}, half_lane};
            LS_WORD: result = rdata;
            default: result = 32'd0;
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// Executes one LDR at a time: memory read, lane extract/extend, register-file write-back.
// Latency: 3 cycles best case, plus REQ stall cycles and WAIT cycles.
// Backpressure: req_ready only in IDLE; mem_rd_en holds with stable address until mem_rd_ready.
module load_unit
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_rd,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    output logic        mem_rd_en,
    output logic [31:0] mem_addr,
    input  logic        mem_rd_ready,
    input  logic        mem_rdata_valid,
    input  logic [31:0] mem_rdata,
    output logic [31:0] w_data_ldr,
    output logic [3:0]  w_addr_ldr,
    output logic        w_en_ldr,
    output logic        busy,
    output logic [3:0]  pending_rd,
    output logic        err
);

    load_state_t state, state_nxt;
    logic [31:0] addr_q;
    logic [3:0]  rd_q;
    load_size_t  size_q;
    logic        sgn_q;
    logic [31:0] data_q;
    logic        err_q;
    logic        accept;
    logic        reject;
    logic        capture;
    logic [31:0] aligned;

    load_align u_align (
        .rdata     (mem_rdata),
        .addr_lo   (addr_q[1:0]),
        .size      (size_q),
        .is_signed (sgn_q),
        .result    (aligned)
    );

    assign accept = req_valid & (state == ST_IDLE);
    assign reject = load_reject(req_addr[1:0], load_size_t'(req_size), req_rd);
    // Data is only taken at the REQ handshake or while in WAIT; anything else is stale.
    assign capture = mem_rdata_valid & (((state == ST_REQ) & mem_rd_ready) | (state == ST_WAIT));

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept && !reject) state_nxt = ST_REQ;
            ST_REQ:  if (mem_rd_ready) state_nxt = mem_rdata_valid ? ST_WB : ST_WAIT;
            ST_WAIT: if (mem_rdata_valid) state_nxt = ST_WB;
            ST_WB:   state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            addr_q <= 32'd0;
            rd_q   <= 4'd0;
            size_q <= LS_BYTE;
            sgn_q  <= 1'b0;
            data_q <= 32'd0;
            err_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            err_q <= accept & reject;
            if (accept) begin
                addr_q <= req_addr;
                rd_q   <= req_rd;
                size_q <= load_size_t'(req_size);
                sgn_q  <= req_signed;
            end
            if (capture) data_q <= aligned;
        end
    end

    // Every output is a state decode or a register, gated to zero outside its active state.
    assign req_ready  = (state == ST_IDLE);
    assign mem_rd_en  = (state == ST_REQ);
    assign mem_addr   = mem_rd_en ? {addr_q[31:2], 2'b00} : 32'd0;
    assign w_en_ldr   = (state == ST_WB);
    assign w_addr_ldr = w_en_ldr ? rd_q : 4'd0;
    assign w_data_ldr = w_en_ldr ? data_q : 32'd0;
    assign busy       = (state != ST_IDLE);
    assign pending_rd = busy ? rd_q : 4'd0;
    assign err        = err_q;

endmodule
